mem_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer sitting in front of the 9-bit even-parity associative memory. Accepts read/write requests from two independent masters and serialises them onto the memory's single `write`/`read` strobe interface. On writes the memory generates the parity bit itself; on reads this block checks even parity and returns data with a parity-error flag. A saturating error counter is kept for debug.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_rr_arb2.sv | 19 +
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
// The parity helper accepts a zero-extended word so it works for any DATA_W up to 63.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_STROBE = 3'd1,
        RD_STROBE = 3'd2,
        RD_WAIT   = 3'd3,
        RESP      = 3'd4
    } state_e;

    function automatic logic even_parity_ok(input logic [63:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: with both requesters valid, the one not served last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last,
    output logic               grant
);

    always_comb begin
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer serialising two masters onto a single
// strobe-driven parity memory; checks read parity and counts errors.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic                      pclk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_perr,
    output logic                      mem_write,
    output logic                      mem_read,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_data_in,
    input  logic [DATA_W:0]           mem_data_out,
    output logic [7:0]                perr_count
);

    localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

    state_e              state_reg;
    state_e              state_next;
    logic                owner_reg;
    logic                write_reg;
    logic                last_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [3:0]          wait_cnt_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                perr_reg;
    logic [7:0]          perr_count_reg;

    logic                grant;
    logic                accept;
    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    rr_arb2 u_rr (
        .valid (req_valid),
        .last  (last_reg),
        .grant (grant)
    );

    // Ready is held low while reset is asserted so no master believes it was accepted.
    assign accept = (state_reg == IDLE) && reset_n && (|req_valid);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        assign req_ready[gi] = accept && (grant == 1'(gi));
        assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (accept) state_next = req_write[grant] ? WR_STROBE : RD_STROBE;
            WR_STROBE: state_next = RESP;
            RD_STROBE: state_next = RD_WAIT;
            RD_WAIT:   if (wait_cnt_reg == 4'd0) state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            write_reg      <= 1'b0;
            last_reg       <= 1'b1;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wait_cnt_reg   <= 4'd0;
            rdata_reg      <= '0;
            perr_reg       <= 1'b0;
            perr_count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                owner_reg <= grant;
                write_reg <= req_write[grant];
                addr_reg  <= addr_arr[grant];
                wdata_reg <= wdata_arr[grant];
                last_reg  <= grant;
            end

            if (state_reg == RD_STROBE) begin
                wait_cnt_reg <= WAIT_INIT;
            end else if (state_reg == RD_WAIT && wait_cnt_reg != 4'd0) begin
                wait_cnt_reg <= wait_cnt_reg - 4'd1;
            end

            // The memory word is sampled exactly RD_LAT cycles after the read strobe.
            if (state_reg == RD_WAIT && wait_cnt_reg == 4'd0) begin
                rdata_reg <= mem_data_out[DATA_W-1:0];
                perr_reg  <= ~even_parity_ok(64'(mem_data_out));
            end

            if (state_reg == RESP && !write_reg && perr_reg && perr_count_reg != 8'hFF) begin
                perr_count_reg <= perr_count_reg + 8'd1;
            end
        end
    end

    assign mem_write   = (state_reg == WR_STROBE);
    assign mem_read    = (state_reg == RD_STROBE);
    assign mem_address = addr_reg;
    assign mem_data_in = wdata_reg;
    assign rsp_rdata   = (state_reg == RESP && !write_reg) ? rdata_reg : '0;
    assign rsp_perr    = (state_reg == RESP && !write_reg) ? perr_reg : 1'b0;
    assign perr_count  = perr_count_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-requester drivers push expectations
// on acceptance, independent monitors check responses and memory strobes.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    typedef struct { bit wr; bit withdraw; logic [31:0] addr; logic [7:0] data; } cmd_t;
    typedef struct { int id; bit wr; logic [7:0] rdata; bit perr; int cyc; } rsp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [7:0] data; int cyc; } stb_t;
    typedef struct { int id; int cyc; } acc_t;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    wire  [1:0]  req_valid;
    wire  [1:0]  req_write;
    wire  [63:0] req_addr;
    wire  [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_perr;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [7:0]  mem_data_in;
    logic [8:0]  mem_data_out = 9'h000;
    logic [7:0]  perr_count;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   force_bad = 1'b0;
    bit   busy [2];
    int   exp_cnt = 0;
    bit   cnt_chk = 1'b0;

    cmd_t cmdq [2][$];
    rsp_t rspq [$];
    stb_t stbq [$];
    acc_t acc_log [$];
    logic [7:0] ref_mem [logic [31:0]];
    logic [8:0] mem_store [logic [31:0]];

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .pclk         (pclk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_perr     (rsp_perr),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .perr_count   (perr_count)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory stand-in: stores {even parity, data}; the fault flag substitutes a bad word.
    always @(posedge pclk) begin
        if (mem_write) mem_store[mem_address] = {^mem_data_in, mem_data_in};
        if (mem_read) begin
            if (force_bad)                       mem_data_out <= 9'h1A5;
            else if (mem_store.exists(mem_address)) mem_data_out <= mem_store[mem_address];
            else                                 mem_data_out <= 9'h000;
        end
    end

    task automatic record_accept(input int id, input cmd_t c);
        rsp_t r;
        stb_t s;
        acc_t a;
        a.id = id; a.cyc = cyc;
        acc_log.push_back(a);
        s.wr = c.wr; s.addr = c.addr; s.data = c.data; s.cyc = cyc + 1;
        stbq.push_back(s);
        r.id = id; r.wr = c.wr;
        if (c.wr) begin
            ref_mem[c.addr] = c.data;
            r.rdata = 8'h00; r.perr = 1'b0; r.cyc = cyc + 2;
        end else begin
            // 0xA5 has four ones, so the forced word with bit 8 set is odd overall.
            if (force_bad) begin
                r.rdata = 8'hA5; r.perr = 1'b1;
            end else begin
                r.rdata = ref_mem.exists(c.addr) ? ref_mem[c.addr] : 8'h00;
                r.perr = 1'b0;
            end
            r.cyc = cyc + 2 + RD_LAT;
        end
        rspq.push_back(r);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_drv
        logic        v = 1'b0;
        logic        w = 1'b0;
        logic [31:0] a = '0;
        logic [7:0]  d = '0;
        assign req_valid[gi]          = v;
        assign req_write[gi]          = w;
        assign req_addr[gi*32 +: 32]  = a;
        assign req_wdata[gi*8 +: 8]   = d;

        initial begin
            cmd_t c;
            int   n;
            busy[gi] = 1'b0;
            forever begin
                if (cmdq[gi].size() == 0) begin
                    v = 1'b0;
                    @(posedge pclk); #1;
                end else begin
                    c = cmdq[gi].pop_front();
                    busy[gi] = 1'b1;
                    v = 1'b1; w = c.wr; a = c.addr; d = c.data;
                    if (c.withdraw) begin
                        @(negedge pclk);
                        chk($sformatf("withdraw_ready_req%0d", gi), 64'(req_ready[gi]), 64'(0));
                        @(posedge pclk); #1;
                        v = 1'b0;
                    end else begin
                        n = 0;
                        @(negedge pclk);
                        while (!(req_ready[gi] && reset_n) && n < 200) begin
                            @(negedge pclk);
                            n++;
                        end
                        if (n >= 200) begin
                            tests++; fails++;
                            $display("[TB] FAIL accept_timeout req%0d actual=no_ready required=ready", gi);
                        end else begin
                            record_accept(gi, c);
                        end
                        @(posedge pclk); #1;
                    end
                    busy[gi] = 1'b0;
                end
            end
        end
    end

    rsp_t mon_r;
    always @(negedge pclk) begin
        if (cnt_chk) begin
            chk("perr_count", 64'(perr_count), 64'(exp_cnt));
            cnt_chk = 1'b0;
        end
        if (rsp_valid != 2'b00) begin
            if (rspq.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL unexpected_rsp actual rsp_valid=%b required=00", rsp_valid);
            end else begin
                mon_r = rspq.pop_front();
                $display("[TB] rsp req%0d %s rdata=%02h perr=%0d cycle=%0d", mon_r.id,
                         mon_r.wr ? "write" : "read", rsp_rdata, rsp_perr, cyc);
                chk("rsp_valid", 64'(rsp_valid), 64'(2'b01 << mon_r.id));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_r.rdata));
                chk("rsp_perr", 64'(rsp_perr), 64'(mon_r.perr));
                chk("rsp_cycle", 64'(cyc), 64'(mon_r.cyc));
                if (!mon_r.wr) begin
                    if (mon_r.perr && exp_cnt < 255) exp_cnt++;
                    cnt_chk = 1'b1;
                end
            end
        end
    end

    stb_t mon_s;
    int   last_hi = -10;
    bit   prev_hi = 1'b0;
    bit   hi;
    always @(negedge pclk) begin
        hi = mem_write | mem_read;
        if (hi) begin
            chk("strobe_overlap", 64'(mem_write & mem_read), 64'(0));
            chk("strobe_width_prev_low", 64'(prev_hi), 64'(0));
            chk("strobe_gap_ge2", 64'(cyc - last_hi >= 3), 64'(1));
            last_hi = cyc;
            if (stbq.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL unexpected_strobe actual wr=%0d rd=%0d required=none", mem_write, mem_read);
            end else begin
                mon_s = stbq.pop_front();
                chk("strobe_is_write", 64'(mem_write), 64'(mon_s.wr));
                chk("strobe_addr", 64'(mem_address), 64'(mon_s.addr));
                if (mon_s.wr) chk("strobe_wdata", 64'(mem_data_in), 64'(mon_s.data));
                chk("strobe_cycle", 64'(cyc), 64'(mon_s.cyc));
            end
        end
        prev_hi = hi;
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"},   64'(req_ready),   64'(0));
        chk({tag, "_rsp_valid"},   64'(rsp_valid),   64'(0));
        chk({tag, "_mem_write"},   64'(mem_write),   64'(0));
        chk({tag, "_mem_read"},    64'(mem_read),    64'(0));
        chk({tag, "_mem_address"}, 64'(mem_address), 64'(0));
        chk({tag, "_mem_data_in"}, 64'(mem_data_in), 64'(0));
        chk({tag, "_rsp_rdata"},   64'(rsp_rdata),   64'(0));
        chk({tag, "_rsp_perr"},    64'(rsp_perr),    64'(0));
        chk({tag, "_perr_count"},  64'(perr_count),  64'(0));
    endtask

    task automatic push(input int id, input bit wr, input logic [31:0] addr, input logic [7:0] data);
        cmd_t c;
        c.wr = wr; c.withdraw = 1'b0; c.addr = addr; c.data = data;
        cmdq[id].push_back(c);
    endtask

    task automatic drain(input string tag, input int bound);
        int k = 0;
        while (k < bound && !(cmdq[0].size() == 0 && cmdq[1].size() == 0 && !busy[0] && !busy[1]
                              && rspq.size() == 0 && stbq.size() == 0)) begin
            @(posedge pclk);
            k++;
        end
        chk({tag, "_drain_timeout"}, 64'(k >= bound), 64'(0));
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   exp_order [4] = '{0, 1, 0, 1};
        cmd_t wc;
        int   k;

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk_reset_values("reset");

        // Contention: both requesters valid from reset.
        push(0, 1'b1, 32'h20, 8'h11);
        push(0, 1'b1, 32'h22, 8'h33);
        push(1, 1'b1, 32'h21, 8'h22);
        push(1, 1'b1, 32'h23, 8'h44);
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("ready_in_reset", 64'(req_ready), 64'(0));
        @(posedge pclk); #1;
        reset_n = 1'b1;
        drain("contention", 200);
        chk("contention_count", 64'(acc_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
            chk($sformatf("grant_order_%0d", i), 64'(acc_log[i].id), 64'(exp_order[i]));
            if (i > 0) chk($sformatf("accept_gap_%0d", i), 64'(acc_log[i].cyc - acc_log[i-1].cyc), 64'(3));
        end

        // Write then read back on requester 0.
        acc_log.delete();
        push(0, 1'b1, 32'h10, 8'hA5);
        push(0, 1'b0, 32'h10, 8'h00);
        drain("wr_rd", 200);
        chk("wr_rd_count", 64'(acc_log.size()), 64'(2));
        if (acc_log.size() == 2) chk("wr_then_accept_gap", 64'(acc_log[1].cyc - acc_log[0].cyc), 64'(3));

        // Requester 1 briefly raises valid while requester 0 is in flight.
        acc_log.delete();
        push(0, 1'b0, 32'h20, 8'h00);
        k = 0;
        while (acc_log.size() == 0 && k < 100) begin @(negedge pclk); k++; end
        chk("withdraw_first_accept", 64'(acc_log.size()), 64'(1));
        wc.wr = 1'b1; wc.withdraw = 1'b1; wc.addr = 32'h30; wc.data = 8'h77;
        cmdq[1].push_back(wc);
        drain("withdraw", 200);
        chk("withdraw_accepts", 64'(acc_log.size()), 64'(1));

        // Parity fault on requester 1 reads, run long enough to saturate.
        force_bad = 1'b1;
        for (int i = 0; i < 300; i++) push(1, 1'b0, 32'h10, 8'h00);
        drain("parity", 3000);
        chk("perr_count_saturated", 64'(perr_count), 64'(255));
        force_bad = 1'b0;

        // Back-to-back mixed traffic from both requesters.
        for (int i = 0; i < 120; i++) begin
            push(0, (i % 3) != 2, 32'h100 + 32'(i % 8), 8'(i * 37));
            push(1, (i % 2) == 0, 32'h100 + 32'((i + 3) % 8), 8'(i * 53 + 1));
        end
        drain("mixed", 4000);

        // Reset asserted while a read is waiting for memory data.
        push(0, 1'b0, 32'h10, 8'h00);
        k = 0;
        @(negedge pclk);
        while (!mem_read && k < 100) begin @(negedge pclk); k++; end
        chk("midrd_read_seen", 64'(mem_read), 64'(1));
        @(posedge pclk); #1;
        reset_n = 1'b0;
        rspq.delete();
        stbq.delete();
        exp_cnt = 0;
        cnt_chk = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk_reset_values("midrd");
        repeat (3) @(posedge pclk);
        #1;
        reset_n = 1'b1;
        push(0, 1'b0, 32'h10, 8'h00);
        drain("post_reset_read", 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
